// File: rtl/multicycle_control_fsm.sv
// Moore-style multicycle control sequencer for the 16-bit processor datapath.
// Walks fetch/decode/execute/memory/writeback and drives every C_* strobe from the current state.
module multicycle_control_fsm #(
   parameter int HALT_ON_ILLEGAL = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] instruction,
   output logic        C_PCWrite,
   output logic        C_MDin,
   output logic        C_MRead,
   output logic        C_MWrite,
   output logic        C_RFRead,
   output logic        C_RDWrite,
   output logic        C_SPWrite,
   output logic        C_AWrite,
   output logic        C_BWrite,
   output logic        C_IRWrite,
   output logic        C_ALUInA,
   output logic        C_ALUOutWrite,
   output logic        C_Branch,
   output logic        C_SPRel,
   output logic        C_PshPop,
   output logic [1:0]  C_PCSrc,
   output logic [1:0]  C_MAddr,
   output logic [1:0]  C_RFWA,
   output logic [1:0]  C_ALUInB,
   output logic [3:0]  C_ALUOp,
   output logic [2:0]  C_RFWD,
   output logic [3:0]  C_DEBUG_NextState,
   output logic        Halted
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_WB_R   = 4'd3,
      S_EXEC_I = 4'd4,
      S_WB_I   = 4'd5,
      S_MEM_RD = 4'd6,
      S_WB_MEM = 4'd7,
      S_MEM_WR = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_PUSH   = 4'd11,
      S_POP    = 4'd12,
      S_WB_POP = 4'd13,
      S_HALT   = 4'd14,
      S_IDLE   = 4'd15
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;

   state_e     state_q;
   state_e     state_d;
   logic [3:0] opcode;
   logic       unused_instr_bits;

   assign opcode            = instruction[15:12];
   assign unused_instr_bits = ^instruction[11:4];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The debug port mirrors what the register will load, so it must reflect reset too.
   assign C_DEBUG_NextState = RESET ? S_IDLE : state_d;

   always_comb begin
      state_d       = state_q;
      C_PCWrite     = 1'b0;
      C_MDin        = 1'b0;
      C_MRead       = 1'b0;
      C_MWrite      = 1'b0;
      C_RFRead      = 1'b0;
      C_RDWrite     = 1'b0;
      C_SPWrite     = 1'b0;
      C_AWrite      = 1'b0;
      C_BWrite      = 1'b0;
      C_IRWrite     = 1'b0;
      C_ALUInA      = 1'b0;
      C_ALUOutWrite = 1'b0;
      C_Branch      = 1'b0;
      C_SPRel       = 1'b0;
      C_PshPop      = 1'b0;
      C_PCSrc       = 2'd0;
      C_MAddr       = 2'd0;
      C_RFWA        = 2'd0;
      C_ALUInB      = 2'd0;
      C_ALUOp       = ALU_ADD;
      C_RFWD        = 3'd0;
      Halted        = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            C_MRead   = 1'b1;
            C_MAddr   = 2'd0;
            C_IRWrite = 1'b1;
            C_ALUInA  = 1'b0;
            C_ALUInB  = 2'd1;
            C_ALUOp   = ALU_ADD;
            C_PCSrc   = 2'd0;
            C_PCWrite = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is precomputed here while the register operands are read.
            C_RFRead      = 1'b1;
            C_AWrite      = 1'b1;
            C_BWrite      = 1'b1;
            C_ALUInA      = 1'b0;
            C_ALUInB      = 2'd2;
            C_ALUOp       = ALU_ADD;
            C_ALUOutWrite = 1'b1;
            case (opcode)
               4'h0:             state_d = S_EXEC_R;
               4'h1, 4'h2, 4'h3: state_d = S_EXEC_I;
               4'h4:             state_d = S_BRANCH;
               4'h5:             state_d = S_JUMP;
               4'h6:             state_d = S_PUSH;
               4'h7:             state_d = S_POP;
               default:          state_d = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
            endcase
         end
         S_EXEC_R: begin
            C_ALUInA      = 1'b1;
            C_ALUInB      = 2'd0;
            C_ALUOp       = instruction[3:0];
            C_ALUOutWrite = 1'b1;
            state_d       = S_WB_R;
         end
         S_WB_R: begin
            C_RDWrite = 1'b1;
            C_RFWA    = 2'd0;
            C_RFWD    = 3'd0;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            C_ALUInA      = 1'b1;
            C_ALUInB      = 2'd3;
            C_ALUOp       = ALU_ADD;
            C_ALUOutWrite = 1'b1;
            case (opcode)
               4'h1:    state_d = S_WB_I;
               4'h2:    state_d = S_MEM_RD;
               4'h3:    state_d = S_MEM_WR;
               default: state_d = S_FETCH;
            endcase
         end
         S_WB_I: begin
            C_RDWrite = 1'b1;
            C_RFWA    = 2'd1;
            C_RFWD    = 3'd0;
            state_d   = S_FETCH;
         end
         S_MEM_RD: begin
            C_MRead = 1'b1;
            C_MAddr = 2'd1;
            state_d = S_WB_MEM;
         end
         S_WB_MEM: begin
            C_RDWrite = 1'b1;
            C_RFWA    = 2'd1;
            C_RFWD    = 3'd1;
            state_d   = S_FETCH;
         end
         S_MEM_WR: begin
            C_MWrite = 1'b1;
            C_MAddr  = 2'd1;
            C_MDin   = 1'b0;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            // PC write is qualified by Zero in the datapath; never strobe PCWrite here.
            C_ALUInA = 1'b1;
            C_ALUInB = 2'd0;
            C_ALUOp  = ALU_SUB;
            C_Branch = 1'b1;
            C_PCSrc  = 2'd1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            C_PCSrc   = 2'd2;
            C_PCWrite = 1'b1;
            state_d   = S_FETCH;
         end
         S_PUSH: begin
            C_MWrite  = 1'b1;
            C_MAddr   = 2'd2;
            C_MDin    = 1'b1;
            C_SPWrite = 1'b1;
            C_PshPop  = 1'b1;
            C_SPRel   = 1'b1;
            state_d   = S_FETCH;
         end
         S_POP: begin
            C_MRead   = 1'b1;
            C_MAddr   = 2'd2;
            C_SPWrite = 1'b1;
            C_PshPop  = 1'b0;
            C_SPRel   = 1'b1;
            state_d   = S_WB_POP;
         end
         S_WB_POP: begin
            C_RDWrite = 1'b1;
            C_RFWA    = 2'd1;
            C_RFWD    = 3'd1;
            state_d   = S_FETCH;
         end
         S_HALT: begin
            Halted  = 1'b1;
            state_d = S_HALT;
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: a halting instance and a
// non-halting instance run side by side against an instruction-level reference model.
module tb_multicycle_control_fsm;

   typedef struct packed {
      logic       pcw, mdin, mread, mwrite, rfread, rdwrite, spwrite, awrite;
      logic       bwrite, irwrite, aluina, aluoutw, branch, sprel, pshpop;
      logic [1:0] pcsrc, maddr, rfwa, aluinb;
      logic [3:0] aluop;
      logic [2:0] rfwd;
      logic       halted;
   } outs_t;

   typedef struct packed {
      outs_t      o1;
      logic [3:0] n1;
      outs_t      o2;
      logic [3:0] n2;
   } entry_t;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] instruction = 16'h0000;
   logic [15:0] instr2 = 16'h8000;
   logic [30:0] act1, act2;
   logic [3:0]  nxt1, nxt2;

   entry_t sb[$];
   int     n_checks = 0;
   int     n_fail = 0;
   int     ms = 15;
   int     m2 = 15;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.HALT_ON_ILLEGAL(1)) dut (
      .CLK(clk), .RESET(RESET), .instruction(instruction),
      .C_PCWrite(act1[30]), .C_MDin(act1[29]), .C_MRead(act1[28]), .C_MWrite(act1[27]),
      .C_RFRead(act1[26]), .C_RDWrite(act1[25]), .C_SPWrite(act1[24]), .C_AWrite(act1[23]),
      .C_BWrite(act1[22]), .C_IRWrite(act1[21]), .C_ALUInA(act1[20]), .C_ALUOutWrite(act1[19]),
      .C_Branch(act1[18]), .C_SPRel(act1[17]), .C_PshPop(act1[16]),
      .C_PCSrc(act1[15:14]), .C_MAddr(act1[13:12]), .C_RFWA(act1[11:10]), .C_ALUInB(act1[9:8]),
      .C_ALUOp(act1[7:4]), .C_RFWD(act1[3:1]), .C_DEBUG_NextState(nxt1), .Halted(act1[0])
   );

   multicycle_control_fsm #(.HALT_ON_ILLEGAL(0)) dut_nohalt (
      .CLK(clk), .RESET(RESET), .instruction(instr2),
      .C_PCWrite(act2[30]), .C_MDin(act2[29]), .C_MRead(act2[28]), .C_MWrite(act2[27]),
      .C_RFRead(act2[26]), .C_RDWrite(act2[25]), .C_SPWrite(act2[24]), .C_AWrite(act2[23]),
      .C_BWrite(act2[22]), .C_IRWrite(act2[21]), .C_ALUInA(act2[20]), .C_ALUOutWrite(act2[19]),
      .C_Branch(act2[18]), .C_SPRel(act2[17]), .C_PshPop(act2[16]),
      .C_PCSrc(act2[15:14]), .C_MAddr(act2[13:12]), .C_RFWA(act2[11:10]), .C_ALUInB(act2[9:8]),
      .C_ALUOp(act2[7:4]), .C_RFWD(act2[3:1]), .C_DEBUG_NextState(nxt2), .Halted(act2[0])
   );

   // Control word each state must present, straight from the state/output table.
   function automatic outs_t exp_out(input int st, input logic [15:0] ins);
      outs_t o = '0;
      case (st)
         0:  begin o.mread = 1; o.irwrite = 1; o.aluinb = 2'd1; o.pcw = 1; end
         1:  begin o.rfread = 1; o.awrite = 1; o.bwrite = 1; o.aluinb = 2'd2; o.aluoutw = 1; end
         2:  begin o.aluina = 1; o.aluop = ins[3:0]; o.aluoutw = 1; end
         3:  begin o.rdwrite = 1; end
         4:  begin o.aluina = 1; o.aluinb = 2'd3; o.aluoutw = 1; end
         5:  begin o.rdwrite = 1; o.rfwa = 2'd1; end
         6:  begin o.mread = 1; o.maddr = 2'd1; end
         7:  begin o.rdwrite = 1; o.rfwa = 2'd1; o.rfwd = 3'd1; end
         8:  begin o.mwrite = 1; o.maddr = 2'd1; end
         9:  begin o.aluina = 1; o.aluop = 4'd1; o.branch = 1; o.pcsrc = 2'd1; end
         10: begin o.pcsrc = 2'd2; o.pcw = 1; end
         11: begin o.mwrite = 1; o.maddr = 2'd2; o.mdin = 1; o.spwrite = 1; o.pshpop = 1; o.sprel = 1; end
         12: begin o.mread = 1; o.maddr = 2'd2; o.spwrite = 1; o.sprel = 1; end
         13: begin o.rdwrite = 1; o.rfwa = 2'd1; o.rfwd = 3'd1; end
         14: begin o.halted = 1; end
         default: ;
      endcase
      return o;
   endfunction

   // State walk of one instruction starting at FETCH; illegal opcodes stop after DECODE.
   function automatic void path_of(input logic [3:0] op, output int p[$]);
      p = {0, 1};
      case (op)
         4'h0: p = {p, 2, 3};
         4'h1: p = {p, 4, 5};
         4'h2: p = {p, 4, 6, 7};
         4'h3: p = {p, 4, 8};
         4'h4: p = {p, 9};
         4'h5: p = {p, 10};
         4'h6: p = {p, 11};
         4'h7: p = {p, 12, 13};
         default: ;
      endcase
   endfunction

   task automatic step(input logic rst, input logic [15:0] ins, input int plan);
      entry_t      e;
      int          n1, n2;
      logic [15:0] i2;
      @(posedge clk);
      #1;
      i2          = {4'($urandom_range(8, 15)), 12'($urandom)};
      RESET       = rst;
      instruction = ins;
      instr2      = i2;
      n1          = rst ? 15 : plan;
      n2          = rst ? 15 : ((m2 == 0) ? 1 : 0);
      e.o1        = exp_out(ms, ins);
      e.n1        = 4'(n1);
      e.o2        = exp_out(m2, i2);
      e.n2        = 4'(n2);
      sb.push_back(e);
      ms = n1;
      m2 = n2;
   endtask

   task automatic reset_seq(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b1, 16'($urandom), 15);
      step(1'b0, 16'($urandom), 0);
   endtask

   // rst_at >= 0 asserts RESET during that cycle of the instruction's walk.
   task automatic run_instr(input logic [15:0] ins, input int rst_at);
      int p[$];
      int nxt;
      path_of(ins[15:12], p);
      for (int i = 0; i < p.size(); i++) begin
         if (i == rst_at) begin
            step(1'b1, ins, 15);
            step(1'b0, 16'($urandom), 0);
            return;
         end
         if (i + 1 < p.size()) nxt = p[i+1];
         else if (ins[15]) nxt = 14;
         else nxt = 0;
         step(1'b0, (i == 0) ? 16'($urandom) : ins, nxt);
      end
      if (ins[15]) begin
         for (int k = 0; k < 10; k++) step(1'b0, 16'($urandom), 14);
         reset_seq(2);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   initial begin : monitor
      entry_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("outs_halting", {1'b0, act1}, {1'b0, e.o1});
            chk("next_halting", {28'd0, nxt1}, {28'd0, e.n1});
            chk("outs_nohalt", {1'b0, act2}, {1'b0, e.o2});
            chk("next_nohalt", {28'd0, nxt2}, {28'd0, e.n2});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [15:0] ins;
      logic [3:0]  op;
      reset_seq(1);
      run_instr(16'h0121, -1);
      run_instr(16'h2305, -1);
      run_instr(16'h3305, -1);
      run_instr(16'h4012, -1);
      run_instr(16'h5FFF, -1);
      run_instr(16'h6000, -1);
      run_instr(16'h7000, -1);
      run_instr(16'h1234, -1);
      run_instr(16'h9000, -1);
      run_instr(16'h2305, 3);
      run_instr(16'h0F0F, -1);
      for (int n = 0; n < 300; n++) begin
         op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         ins = {op, 12'($urandom)};
         if ($urandom_range(0, 15) == 0) run_instr(ins, int'($urandom_range(0, 4)));
         else run_instr(ins, -1);
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
